i2c_adc_responder: RTL and testbench
====================================

I2C_ADC_RESPONDER -- requirements
Module: i2c_adc_responder

Interface
REQ-001 Parameter ADDR, default 7'h28, is the 7-bit I2C target address the block responds to.
REQ-002 Parameter CFG_RST, default 8'h00, is the reset value of cfg_reg.
REQ-003 clk input 1: single system clock; the block has one clock and everything runs on it.
REQ-004 rst input 1: reset, asynchronous and active-high.
REQ-005 scl input 1: I2C clock from the initiator; the block never drives or stretches it.
REQ-006 sda inout 1: I2C data, open-drain; the block drives 1'b0 or releases to 1'bz, never drives 1.
REQ-007 sample input 12: ADC sample value to return to the initiator.
REQ-008 sample_req output 1: one-clk pulse when sample is latched for transmission.
REQ-009 cfg_reg output 8: last configuration byte written by the initiator.
REQ-010 cfg_valid output 1: one-clk pulse when cfg_reg is updated.
REQ-011 busy output 1: high while the block is addressed (from address ACK until STOP, repeated START or NACK).

Function
REQ-012 scl and sda in SHALL pass through 2-flop synchronizers; all edge/condition detection uses synchronized values; clk SHALL be at least 8x SCL frequency.
REQ-013 START = synced sda falls while synced scl high; STOP = synced sda rises while synced scl high; both are detected in every state.
REQ-014 States: IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK, WAIT_STOP.
REQ-015 IDLE/WAIT_STOP -> ADDR on START; any state -> ADDR on repeated START; any state -> IDLE on STOP, releasing sda the next clk.
REQ-016 ADDR: shift 8 bits MSB first on synced scl rising edges; on the 8th bit, match [7:1]==ADDR -> ADDR_ACK, else -> WAIT_STOP (sda never driven).
REQ-017 Data sampling: bits are captured on synced scl rising edges; sda is changed only one clk after a synced scl falling edge.
REQ-018 ADDR_ACK: drive sda low for the 9th SCL period; on R/W=1 latch sample, pulse sample_req, and load tx byte0 = {4'b0000, sample[11:8]}; on R/W=0 -> RX_BYTE.
REQ-019 TX_BYTE: drive byte MSB first (bit 0 -> sda low, bit 1 -> release); after 8 bits release sda -> TX_ACK.
REQ-020 TX_ACK: sample initiator bit on the 9th rising edge; ACK (0) -> TX_BYTE with next byte; NACK (1) -> WAIT_STOP.
REQ-021 Byte order: byte0 (high nibble), byte1 = sample[7:0], then wrap: re-latch sample, pulse sample_req, and send byte0 again; the 12-bit value is coherent within each byte pair.
REQ-022 RX_BYTE: shift 8 bits -> RX_ACK; in RX_ACK drive ACK, load cfg_reg with the byte, and pulse cfg_valid once; multiple writes each update cfg_reg; the last byte wins.
REQ-023 busy SHALL be high in ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE and RX_ACK only.
REQ-024 sample changes while a byte pair is in flight SHALL NOT affect the pair.

Reset
REQ-025 When rst is asserted: state IDLE, sda released (z), sample_req 0, cfg_valid 0, busy 0, cfg_reg CFG_RST, shift/bit counters 0, synchronizers loaded with 1.
REQ-026 rst asserted mid-transfer SHALL release sda within the same cycle (asynchronous); after release the block waits for a fresh START.

Verification
REQ-027 Read 0x51 with sample=12'hA5C, initiator ACKs byte0, NACKs byte1 -> address ACK, bytes 8'h0A then 8'h5C, one sample_req pulse, then idle after STOP.
REQ-028 Read with ACK after byte1, sample changed to 12'h123 before the wrap -> third byte 8'h01, fourth byte 8'h23, two sample_req pulses total.
REQ-029 Write 0x50, 8'h3C, STOP -> two ACKs, cfg_reg=8'h3C, one cfg_valid pulse, busy low after STOP.
REQ-030 Address 0x53 -> no ACK (sda stays z through the 9th clock), busy stays 0, and there is no sample_req.
REQ-031 Write 0x50 followed by repeated START and read 0x51 -> address ACKed both times and read data correct; STOP mid-TX_BYTE -> sda released the next clk, state IDLE.
REQ-032 rst pulse during TX_BYTE while driving 0 -> sda z immediately, all outputs at reset values, and the next transaction completes normally.

Source files
------------

// File: rtl/i2c_adc_responder.sv
// I2C target that returns a 12-bit ADC sample as two bytes on reads and
// captures a configuration byte on writes. Everything runs on clk; SCL/SDA are oversampled.
module i2c_adc_responder #(
    parameter logic [6:0] ADDR    = 7'h28,
    parameter logic [7:0] CFG_RST = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [11:0] sample,
    output logic        sample_req,
    output logic [7:0]  cfg_reg,
    output logic        cfg_valid,
    output logic        busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_TX_BYTE   = 3'd3;
    localparam logic [2:0] S_TX_ACK    = 3'd4;
    localparam logic [2:0] S_RX_BYTE   = 3'd5;
    localparam logic [2:0] S_RX_ACK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic       r_fall_p;
    logic [2:0] r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_lo;
    logic       r_rw;
    logic       r_ninth;
    logic       r_sel;
    logic       r_sda_oe;
    logic       r_sample_req;
    logic       r_cfg_valid;
    logic [7:0] r_cfg;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_shift_in;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    assign w_shift_in = {r_shift[6:0], r_sda_s2};

    // Open-drain: only ever pull low; async reset clears r_sda_oe, releasing the line at once
    assign sda        = r_sda_oe ? 1'b0 : 1'bz;
    assign sample_req = r_sample_req;
    assign cfg_valid  = r_cfg_valid;
    assign cfg_reg    = r_cfg;
    assign busy       = (r_state == S_ADDR_ACK) || (r_state == S_TX_BYTE) ||
                        (r_state == S_TX_ACK)   || (r_state == S_RX_BYTE) ||
                        (r_state == S_RX_ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s1     <= 1'b1;
            r_scl_s2     <= 1'b1;
            r_scl_d      <= 1'b1;
            r_sda_s1     <= 1'b1;
            r_sda_s2     <= 1'b1;
            r_sda_d      <= 1'b1;
            r_fall_p     <= 1'b0;
            r_state      <= S_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'd0;
            r_lo         <= 8'd0;
            r_rw         <= 1'b0;
            r_ninth      <= 1'b0;
            r_sel        <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_sample_req <= 1'b0;
            r_cfg_valid  <= 1'b0;
            r_cfg        <= CFG_RST;
        end else begin
            r_scl_s1     <= scl;
            r_scl_s2     <= r_scl_s1;
            r_scl_d      <= r_scl_s2;
            r_sda_s1     <= sda;
            r_sda_s2     <= r_sda_s1;
            r_sda_d      <= r_sda_s2;
            // SDA updates are taken one clk after the detected SCL fall
            r_fall_p     <= w_scl_fall;
            r_sample_req <= 1'b0;
            r_cfg_valid  <= 1'b0;

            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 4'd0;
                r_shift   <= 8'd0;
                r_ninth   <= 1'b0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                r_ninth   <= 1'b0;
                r_sda_oe  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_rw      <= r_sda_s2;
                                r_ninth   <= 1'b0;
                                r_state   <= (w_shift_in[7:1] == ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_rise) begin
                            r_ninth <= 1'b1;
                        end else if (r_fall_p) begin
                            if (!r_ninth) begin
                                r_sda_oe <= 1'b1;
                                if (r_rw) begin
                                    r_shift      <= {4'b0000, sample[11:8]};
                                    r_lo         <= sample[7:0];
                                    r_sample_req <= 1'b1;
                                end
                            end else begin
                                r_ninth   <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                if (r_rw) begin
                                    r_state  <= S_TX_BYTE;
                                    r_sda_oe <= ~r_shift[7];
                                    r_sel    <= 1'b1;
                                end else begin
                                    r_state  <= S_RX_BYTE;
                                    r_sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    S_TX_BYTE: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (r_fall_p) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_ninth   <= 1'b0;
                                r_state   <= S_TX_ACK;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    S_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_s2) r_state <= S_WAIT_STOP;
                            else          r_ninth <= 1'b1;
                        end else if (r_fall_p && r_ninth) begin
                            r_ninth   <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_TX_BYTE;
                            if (r_sel) begin
                                r_shift  <= r_lo;
                                r_sda_oe <= ~r_lo[7];
                                r_sel    <= 1'b0;
                            end else begin
                                // Wrap: take a fresh sample so each byte pair is coherent
                                r_shift      <= {4'b0000, sample[11:8]};
                                r_lo         <= sample[7:0];
                                r_sample_req <= 1'b1;
                                r_sda_oe     <= 1'b1;
                                r_sel        <= 1'b1;
                            end
                        end
                    end
                    S_RX_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_ninth   <= 1'b0;
                                r_state   <= S_RX_ACK;
                            end
                        end
                    end
                    S_RX_ACK: begin
                        if (w_scl_rise) begin
                            r_ninth <= 1'b1;
                        end else if (r_fall_p) begin
                            if (!r_ninth) begin
                                r_sda_oe    <= 1'b1;
                                r_cfg       <= r_shift;
                                r_cfg_valid <= 1'b1;
                            end else begin
                                r_ninth   <= 1'b0;
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_RX_BYTE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_adc_responder.sv
// Directed bench for i2c_adc_responder: bit-banged I2C initiator with
// hand-computed expected bytes, ACKs, pulse counts and reset behaviour.
module tb_i2c_adc_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        tb_sda_low = 1'b0;
    logic [11:0] sample = 12'h000;
    wire         sda;
    logic        sample_req;
    logic [7:0]  cfg_reg;
    logic        cfg_valid;
    logic        busy;

    pullup (sda);
    assign sda = tb_sda_low ? 1'b0 : 1'bz;

    i2c_adc_responder #(.ADDR(7'h28), .CFG_RST(8'h00)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .sample(sample),
        .sample_req(sample_req), .cfg_reg(cfg_reg), .cfg_valid(cfg_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_req  = 0;
    int n_cfg  = 0;
    int n_busy = 0;

    always @(posedge clk) begin
        if (sample_req) n_req  <= n_req + 1;
        if (cfg_valid)  n_cfg  <= n_cfg + 1;
        if (busy)       n_busy <= n_busy + 1;
    end

    localparam int T = 4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_w(input logic b);
        waitc(T); tb_sda_low = ~b;
        waitc(T); scl = 1'b1;
        waitc(2*T); scl = 1'b0;
    endtask

    task automatic bit_r(output logic b);
        waitc(T); tb_sda_low = 1'b0;
        waitc(T); scl = 1'b1;
        waitc(T); b = sda;
        waitc(T); scl = 1'b0;
    endtask

    task automatic i2c_start();
        tb_sda_low = 1'b0;
        waitc(2*T); scl = 1'b1;
        waitc(T); tb_sda_low = 1'b1;
        waitc(T); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        waitc(T); tb_sda_low = 1'b1;
        waitc(T); scl = 1'b1;
        waitc(T); tb_sda_low = 1'b0;
        waitc(2*T);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_r(b);
            d = {d[6:0], b};
        end
        bit_w(ack_bit);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;
        logic [3:0] nib;
        int         base_req, base_cfg, base_busy;

        waitc(5);
        chk("rst_sda", sda, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sample_req", sample_req, 1'b0);
        chk("rst_cfg_valid", cfg_valid, 1'b0);
        chk("rst_cfg_reg", cfg_reg, 8'h00);
        rst = 1'b0;
        waitc(10);

        // Read, ACK byte0, NACK byte1
        sample = 12'hA5C;
        base_req = n_req;
        i2c_start();
        wr_byte(8'h51, ack);
        chk("rd_addr_ack", ack, 1'b0);
        chk("rd_busy", busy, 1'b1);
        rd_byte(d, 1'b0);
        chk("rd_byte0", d, 8'h0A);
        rd_byte(d, 1'b1);
        chk("rd_byte1", d, 8'h5C);
        chk("rd_busy_nack", busy, 1'b0);
        i2c_stop();
        chk("rd_req_cnt", n_req - base_req, 1);
        chk("rd_sda_idle", sda, 1'b1);
        chk("rd_busy_idle", busy, 1'b0);

        // Read with wrap; sample changes mid-pair must not disturb byte1
        sample = 12'hA5C;
        base_req = n_req;
        i2c_start();
        wr_byte(8'h51, ack);
        chk("wrap_addr_ack", ack, 1'b0);
        rd_byte(d, 1'b0);
        chk("wrap_byte0", d, 8'h0A);
        sample = 12'h123;
        rd_byte(d, 1'b0);
        chk("wrap_byte1", d, 8'h5C);
        rd_byte(d, 1'b0);
        chk("wrap_byte2", d, 8'h01);
        rd_byte(d, 1'b1);
        chk("wrap_byte3", d, 8'h23);
        i2c_stop();
        chk("wrap_req_cnt", n_req - base_req, 2);

        // Write one config byte
        base_cfg = n_cfg;
        i2c_start();
        wr_byte(8'h50, ack);
        chk("wr_addr_ack", ack, 1'b0);
        wr_byte(8'h3C, ack);
        chk("wr_data_ack", ack, 1'b0);
        chk("wr_cfg_reg", cfg_reg, 8'h3C);
        chk("wr_cfg_cnt", n_cfg - base_cfg, 1);
        i2c_stop();
        chk("wr_busy_idle", busy, 1'b0);

        // Foreign address: no ACK, never busy, no sample request
        base_req  = n_req;
        base_busy = n_busy;
        i2c_start();
        wr_byte(8'h53, ack);
        chk("nomatch_ack", ack, 1'b1);
        i2c_stop();
        chk("nomatch_busy", n_busy - base_busy, 0);
        chk("nomatch_req", n_req - base_req, 0);

        // Write then repeated START into a read
        i2c_start();
        wr_byte(8'h50, ack);
        chk("rs_wr_ack", ack, 1'b0);
        wr_byte(8'h11, ack);
        chk("rs_data_ack", ack, 1'b0);
        sample = 12'h800;
        i2c_start();
        wr_byte(8'h51, ack);
        chk("rs_rd_ack", ack, 1'b0);
        rd_byte(d, 1'b0);
        chk("rs_byte0", d, 8'h08);
        rd_byte(d, 1'b1);
        chk("rs_byte1", d, 8'h00);
        i2c_stop();
        chk("rs_cfg_reg", cfg_reg, 8'h11);

        // STOP in the middle of a transmitted byte (target releasing bit 3)
        i2c_start();
        wr_byte(8'h51, ack);
        chk("ms_addr_ack", ack, 1'b0);
        nib = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bit_r(b);
            nib = {nib[2:0], b};
        end
        chk("ms_nibble", nib, 4'h0);
        chk("ms_busy_tx", busy, 1'b1);
        i2c_stop();
        chk("ms_busy_idle", busy, 1'b0);
        chk("ms_sda_rel", sda, 1'b1);

        // Async reset while the target is pulling SDA low
        sample = 12'hA5C;
        i2c_start();
        wr_byte(8'h51, ack);
        chk("ar_addr_ack", ack, 1'b0);
        waitc(2*T);
        chk("ar_sda_drv", sda, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("ar_sda_rel", sda, 1'b1);
        chk("ar_busy", busy, 1'b0);
        chk("ar_cfg_reg", cfg_reg, 8'h00);
        chk("ar_sample_req", sample_req, 1'b0);
        chk("ar_cfg_valid", cfg_valid, 1'b0);
        scl = 1'b1;
        waitc(4);
        rst = 1'b0;
        waitc(10);
        i2c_start();
        wr_byte(8'h50, ack);
        chk("ar_wr_ack", ack, 1'b0);
        wr_byte(8'h77, ack);
        chk("ar_data_ack", ack, 1'b0);
        i2c_stop();
        chk("ar_cfg_after", cfg_reg, 8'h77);
        chk("ar_busy_after", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
